// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// memory-wait freeze with timeout to a sticky ERROR state, event counters.
module hazard_ctrl #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rs_e,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  writereg_e,
  input  logic        memtoreg_e,
  input  logic        regwrite_e,
  input  logic [4:0]  writereg_m,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic        branch_m,
  input  logic        zero_m,
  input  logic [4:0]  writereg_w,
  input  logic        regwrite_w,
  input  logic        mem_ready,
  input  logic        counter_clr,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        freeze,
  output logic        flush_w,
  output logic        pcsrc,
  output logic [1:0]  forward_ae,
  output logic [1:0]  forward_be,
  output logic [1:0]  state,
  output logic        error,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MEMWAIT = 2'b01;
  localparam logic [1:0] ERROR   = 2'b10;
  localparam logic [7:0] LIM_M1  = 8'(WAIT_LIMIT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic memacc, memhold, loaduse, taken;
  logic [1:0] fwd_a, fwd_b;

  assign memacc  = memtoreg_m | memwrite_m;
  assign memhold = memacc & ~mem_ready;
  assign taken   = branch_m & zero_m & ~memacc;
  assign loaduse = memtoreg_e & regwrite_e & (writereg_e != 5'd0)
                 & ((writereg_e == rs_d) | (writereg_e == rt_d));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (regwrite_m && writereg_m != 5'd0 && writereg_m == rs_e)
      fwd_a = 2'b10;
    else if (regwrite_w && writereg_w != 5'd0 && writereg_w == rs_e)
      fwd_a = 2'b01;
    if (regwrite_m && writereg_m != 5'd0 && writereg_m == rt_e)
      fwd_b = 2'b10;
    else if (regwrite_w && writereg_w != 5'd0 && writereg_w == rt_e)
      fwd_b = 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    unique case (state_q)
      RUN: begin
        if (memhold) state_d = MEMWAIT;
      end
      MEMWAIT: begin
        if (!memhold) begin
          state_d = RUN;
        end else if (wcnt_q == LIM_M1) begin
          state_d = ERROR;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // Counters saturate; a same-cycle clear wins over the increment.
  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (counter_clr) begin
      scnt_d = '0;
      fcnt_d = '0;
    end else begin
      if ((stall_d | freeze) && scnt_q != 16'hFFFF)
        scnt_d = scnt_q + 16'd1;
      if (pcsrc && fcnt_q != 16'hFFFF)
        fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    freeze     = 1'b0;
    flush_w    = 1'b0;
    pcsrc      = 1'b0;
    forward_ae = 2'b00;
    forward_be = 2'b00;
    if (!reset) begin
      if (state_q == ERROR) begin
        freeze  = 1'b1;
        flush_w = 1'b1;
      end else begin
        forward_ae = fwd_a;
        forward_be = fwd_b;
        if (memhold) begin
          freeze  = 1'b1;
          flush_w = 1'b1;
        end else if (taken) begin
          pcsrc   = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          flush_m = 1'b1;
        end else if (loaduse) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
    end
  end

  assign state       = state_q;
  assign error       = (state_q == ERROR);
  assign stall_count = scnt_q;
  assign flush_count = fcnt_q;

endmodule
